// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the data-memory access unit and its load extender:
//   - access-width codes produced by the decode stage (store and load variants)
//   - FSM state encoding
//   - timeout counter width
//   - helpers that classify an access width and build byte-lane enables
// -----------------------------------------------------------------------------
package mem_access_pkg;

    // Access-width codes as delivered on aluSelect.
    localparam logic [5:0] W_SB  = 6'b010000;
    localparam logic [5:0] W_SH  = 6'b010001;
    localparam logic [5:0] W_SW  = 6'b010010;
    localparam logic [5:0] W_LB  = 6'b001000;
    localparam logic [5:0] W_LH  = 6'b001001;
    localparam logic [5:0] W_LW  = 6'b001010;
    localparam logic [5:0] W_LBU = 6'b001100;
    localparam logic [5:0] W_LHU = 6'b001101;

    // Width of the WAIT-state timeout counter (supports limits up to 1023).
    localparam int TO_CNT_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    // Unknown codes fall through to a full-word access.
    function automatic size_e access_size(input logic [5:0] code);
        size_e size;
        case (code)
            W_SB, W_LB, W_LBU: size = SIZE_BYTE;
            W_SH, W_LH, W_LHU: size = SIZE_HALF;
            default:           size = SIZE_WORD;
        endcase
        return size;
    endfunction

    function automatic logic is_aligned(input size_e size, input logic [1:0] offset);
        logic ok;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = ~offset[0];
            default:   ok = (offset == 2'b00);
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lane_enables(input size_e size, input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << offset;
            SIZE_HALF: be = 4'b0011 << offset;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_extender.sv
// -----------------------------------------------------------------------------
// load_extender
// Combinational load alignment: shifts the addressed byte/halfword of a memory
// word down to bit 0 and sign- or zero-extends it according to the width code.
// Ports:
//   raw    in  32  word as read from memory
//   offset in   2  byte offset within the word (address[1:0])
//   width  in   6  access-width code
//   value  out 32  extended load result
// -----------------------------------------------------------------------------
module load_extender
    import mem_access_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  offset,
    input  logic [5:0]  width,
    output logic [31:0] value
);

    logic [31:0] shifted;

    assign shifted = raw >> {offset, 3'b000};

    always_comb begin
        value = shifted;
        case (width)
            W_LB:    value = {{24{shifted[7]}}, shifted[7:0]};
            W_LBU:   value = {24'h000000, shifted[7:0]};
            W_LH:    value = {{16{shifted[15]}}, shifted[15:0]};
            W_LHU:   value = {16'h0000, shifted[15:0]};
            default: value = shifted;
        endcase
    end

endmodule

// File: rtl/data_mem_access_unit.sv
// -----------------------------------------------------------------------------
// data_mem_access_unit
// Memory-stage controller between the store converter and a word-addressed,
// variable-latency data memory. Lane-aligns stores with byte enables, issues
// a level req/ack handshake, stalls the pipeline while the access is in
// flight, and returns extended load data. Misaligned requests and accesses
// that exceed TIMEOUT_CYCLES in WAIT are reported by one-cycle pulses.
// Ports:
//   clk, resetN                 clock, asynchronous active-low reset
//   memRead, memWrite           request strobes (write wins if both set)
//   aluSelect, address          width code and byte address
//   storeData                   store value in the low bits
//   stall                       hold upstream pipeline
//   loadData, loadValid         extended load result and its valid pulse
//   misaligned, busError        rejection / timeout pulses
//   memReq, memWe, memAddr,
//   memByteEn, memWData         memory command (held stable during WAIT)
//   memRData, memAck            memory read word and completion strobe
// -----------------------------------------------------------------------------
module data_mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        resetN,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [5:0]  aluSelect,
    input  logic [31:0] address,
    input  logic [31:0] storeData,
    output logic        stall,
    output logic [31:0] loadData,
    output logic        loadValid,
    output logic        misaligned,
    output logic        busError,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [3:0]  memByteEn,
    output logic [31:0] memWData,
    input  logic [31:0] memRData,
    input  logic        memAck
);

    localparam logic [TO_CNT_W-1:0] TIMEOUT_LIM = TO_CNT_W'(TIMEOUT_CYCLES);

    state_e              state_reg;
    logic                cmd_we_reg;
    logic [3:0]          cmd_be_reg;
    logic [31:0]         cmd_addr_reg;
    logic [31:0]         cmd_wdata_reg;
    logic [5:0]          cmd_width_reg;
    logic [1:0]          cmd_off_reg;
    logic [TO_CNT_W-1:0] count_reg;
    logic [31:0]         load_data_reg;
    logic                load_valid_reg;
    logic                misaligned_reg;
    logic                bus_error_reg;

    logic                req;
    size_e               req_size;
    logic                req_aligned;
    logic [3:0]          req_be;
    logic [31:0]         req_wdata;
    logic [TO_CNT_W-1:0] count_next;
    logic [31:0]         extended;

    assign req         = memRead | memWrite;
    assign req_size    = access_size(aluSelect);
    assign req_aligned = is_aligned(req_size, address[1:0]);
    assign req_be      = lane_enables(req_size, address[1:0]);
    assign req_wdata   = storeData << {address[1:0], 3'b000};
    assign count_next  = count_reg + 1'b1;

    load_extender u_load_extender (
        .raw    (memRData),
        .offset (cmd_off_reg),
        .width  (cmd_width_reg),
        .value  (extended)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg      <= IDLE;
            cmd_we_reg     <= 1'b0;
            cmd_be_reg     <= '0;
            cmd_addr_reg   <= '0;
            cmd_wdata_reg  <= '0;
            cmd_width_reg  <= '0;
            cmd_off_reg    <= '0;
            count_reg      <= '0;
            load_data_reg  <= '0;
            load_valid_reg <= 1'b0;
            misaligned_reg <= 1'b0;
            bus_error_reg  <= 1'b0;
        end else begin
            // Status outputs are single-cycle pulses unless re-armed below.
            load_valid_reg <= 1'b0;
            misaligned_reg <= 1'b0;
            bus_error_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        if (!req_aligned) begin
                            misaligned_reg <= 1'b1;
                        end else begin
                            cmd_we_reg    <= memWrite;
                            cmd_be_reg    <= req_be;
                            cmd_addr_reg  <= {address[31:2], 2'b00};
                            cmd_wdata_reg <= req_wdata;
                            cmd_width_reg <= aluSelect;
                            cmd_off_reg   <= address[1:0];
                            count_reg     <= '0;
                            state_reg     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Ack is checked first so it wins over a coinciding timeout.
                    if (memAck) begin
                        state_reg <= DONE;
                        if (!cmd_we_reg) begin
                            load_data_reg  <= extended;
                            load_valid_reg <= 1'b1;
                        end
                    end else if (count_next == TIMEOUT_LIM) begin
                        state_reg     <= IDLE;
                        bus_error_reg <= 1'b1;
                        load_data_reg <= '0;
                    end else begin
                        count_reg <= count_next;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Stall covers the request cycle combinationally so the pipeline holds
    // before the FSM has registered the command; gated by reset so it drops
    // immediately when the unit is reset.
    assign stall = resetN & (((state_reg == IDLE) & req) | (state_reg == WAIT));

    assign memReq     = (state_reg == WAIT);
    assign memWe      = cmd_we_reg;
    assign memAddr    = cmd_addr_reg;
    assign memByteEn  = cmd_be_reg;
    assign memWData   = cmd_wdata_reg;
    assign loadData   = load_data_reg;
    assign loadValid  = load_valid_reg;
    assign misaligned = misaligned_reg;
    assign busError   = bus_error_reg;

endmodule

// File: doc/data_mem_access_unit.md
Name: data_mem_access_unit

Overview:
Memory-stage controller that sits directly downstream of the store converter and upstream of data memory. It takes the width-masked store data or a load request and lane-aligns it to a word-addressed data memory using byte enables. It runs a req/ack handshake against variable-latency memory and stalls the pipeline until the access completes. Load data is returned sign- or zero-extended, and the unit flags misaligned accesses and memory timeouts.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles in WAIT before abort (1..1023; counter width 10 bits)

Ports:
clk  in  1  system clock, rising edge
resetN  in  1  asynchronous active-low reset
memRead  in  1  load request this cycle
memWrite  in  1  store request this cycle
aluSelect  in  6  access-width code (package constants)
address  in  32  byte address from ALU
storeData  in  32  masked store data, value in low bits
stall  out  1  hold upstream pipeline
loadData  out  32  extended load result
loadValid  out  1  one-cycle pulse, loadData valid
misaligned  out  1  one-cycle pulse, access rejected
busError  out  1  one-cycle pulse, access timed out
memReq  out  1  memory request, level
memWe  out  1  1 = write
memAddr  out  32  word address (byte address with [1:0] = 0)
memByteEn  out  4  byte-lane enables
memWData  out  32  lane-shifted write data
memRData  in  32  memory read word
memAck  in  1  memory completion, valid one cycle

Behaviour:
- Reset (async, resetN = 0): state IDLE; every output is 0; latched command and timeout counter cleared. Takes effect immediately, mid-transaction included. memReq drops at once, and any in-flight access is abandoned with no pulses.
- Width codes: SB 010000, SH 010001, SW 010010, LB 001000, LH 001001, LW 001010, LBU 001100, LHU 001101. Any other code with a request is treated as a word access.
- Priority: memWrite dominates when memRead and memWrite are both 1.
- Alignment rule: halfword requires address[0] = 0; word requires address[1:0] = 0.
- Misaligned request: misaligned pulses the next cycle, no memory request is issued, and the unit stays in IDLE. stall is asserted only in the request cycle.
- Byte enables and data lanes: byte = 0001 << a[1:0]; half = 0011 << a[1:0]; word = 1111. memWData is storeData shifted left by 8 × a[1:0].
- FSM states: IDLE, WAIT, DONE.
  - IDLE → WAIT on an aligned request. The command (we, byte enables, word address, shifted data, width code, a[1:0]) is registered. stall is driven combinationally high in the request cycle.
  - WAIT: memReq = 1 and stall = 1; memAddr, memWe, memByteEn and memWData are held stable.
  - WAIT → DONE on memAck. For a read, memRData is captured, shifted right by 8 × a[1:0], then sign- or zero-extended.
  - WAIT → IDLE when the counter reaches TIMEOUT_CYCLES: busError pulses, loadData is forced to 0, memReq drops.
  - DONE: memReq = 0 and stall = 0. loadValid pulses for reads only. Always returns to IDLE next cycle; a new request in DONE is not accepted until IDLE.
- Latency: an ack on the first WAIT cycle gives a 3-cycle access (request, WAIT, DONE).
- Timeout counter: cleared on entry to WAIT, incremented on each WAIT cycle without ack. If ack and timeout coincide, the ack wins.
- memAck outside WAIT is ignored.
- loadData holds its last value between loads.

Decomposition:
- Shared package `mem_access_pkg`:
  - the eight width-code constants;
  - state encoding (IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2);
  - TIMEOUT counter width.
- One natural sub-module, `load_extender`: combinational; inputs raw word, byte offset and width code; output extended 32-bit value. Reused later by forwarding logic.

Test Plan:
1. SB, address 0x1003, storeData 0x000000AB, ack after 2 WAIT cycles → memAddr 0x1000, memByteEn 1000, memWData 0xAB000000, memWe = 1, stall high for 3 cycles, no loadValid.
2. LH, address 0x2002, memRData 0x8001_1234, immediate ack → loadData 0xFFFF8001 with loadValid pulse in DONE. Same access as LHU → 0x00008001.
3. LW, address 0x3001 → misaligned pulse, memReq never asserted, state back to IDLE. Same for SH at 0x3003.
4. SW, address 0x4000, memAck withheld, TIMEOUT_CYCLES = 4 → busError pulse after 4 WAIT cycles, memReq falls, stall falls.
5. memRead and memWrite both high at 0x5000 → write issued (memWe = 1, byte enables 1111), no loadValid.
6. resetN pulled low mid-WAIT → memReq, stall and all pulses are 0 immediately. After release, a stray memAck is ignored and a fresh LB at 0x6001 with memRData 0x0000_F000 returns 0xFFFFFFF0.
